// File: rtl/sseg_disp_mux.sv
// Scans four latched active-low seven-segment patterns onto a common-anode 4-digit display.
// Outputs are registered and lag the refresh counter by one cycle; en=0 blanks and freezes the scan.
module sseg_disp_mux #(
    parameter int N = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    input  logic       load,
    input  logic       en,
    output logic [3:0] an,
    output logic [7:0] sseg,
    output logic       frame_tick
);

    logic [N-1:0] r_q;
    logic [7:0]   r_shadow [4];
    logic [3:0]   r_an;
    logic [7:0]   r_sseg;
    logic         r_frame_tick;

    logic [1:0]   w_sel;
    logic [3:0]   w_an_dec;
    logic [7:0]   w_pat;
    logic         w_q_max;

    assign w_sel    = r_q[N-1:N-2];
    assign w_an_dec = ~(4'b0001 << w_sel);
    assign w_pat    = r_shadow[w_sel];
    assign w_q_max  = &r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow <= '{default: 8'hFF};
        end else if (load) begin
            r_shadow[0] <= in0;
            r_shadow[1] <= in1;
            r_shadow[2] <= in2;
            r_shadow[3] <= in3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= r_q + 1'b1;
        end
    end

    // Pattern is taken from the pre-edge shadow, so a load coinciding with a digit change shows old data once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an         <= 4'b1111;
            r_sseg       <= 8'hFF;
            r_frame_tick <= 1'b0;
        end else if (en) begin
            r_an         <= w_an_dec;
            r_sseg       <= w_pat;
            r_frame_tick <= w_q_max;
        end else begin
            r_an         <= 4'b1111;
            r_sseg       <= 8'hFF;
            r_frame_tick <= 1'b0;
        end
    end

    assign an         = r_an;
    assign sseg       = r_sseg;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_sseg_disp_mux.sv
// Self-checking bench for sseg_disp_mux: directed vector table (N=4), directed N=3 scan,
// async reset checks and a randomized run against a cycle-level reference model.
module tb_sseg_disp_mux;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in0 = 8'h00, in1 = 8'h00, in2 = 8'h00, in3 = 8'h00;
    logic       load = 1'b0;
    logic       en = 1'b0;

    logic [3:0] an4, an3;
    logic [7:0] sseg4, sseg3;
    logic       ft4, ft3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sseg_disp_mux #(.N(4)) dut4 (
        .clk(clk), .reset(reset), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .load(load), .en(en), .an(an4), .sseg(sseg4), .frame_tick(ft4)
    );

    sseg_disp_mux #(.N(3)) dut3 (
        .clk(clk), .reset(reset), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .load(load), .en(en), .an(an3), .sseg(sseg3), .frame_tick(ft3)
    );

    // Reference model: integer refresh position per instance, digit = position / cycles-per-digit.
    int         m_q   [2];
    logic [7:0] m_sh  [4];
    logic [3:0] m_an  [2];
    logic [7:0] m_ss  [2];
    logic       m_ft  [2];
    int         m_per [2] = '{4, 2};

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_q[i]  <= 0;
                m_an[i] <= 4'hF;
                m_ss[i] <= 8'hFF;
                m_ft[i] <= 1'b0;
            end
            for (int k = 0; k < 4; k++) m_sh[k] <= 8'hFF;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (en) begin
                    m_an[i] <= 4'hF & ~(4'(1) << (m_q[i] / m_per[i]));
                    m_ss[i] <= m_sh[m_q[i] / m_per[i]];
                    m_ft[i] <= (m_q[i] == 4 * m_per[i] - 1);
                    m_q[i]  <= (m_q[i] + 1) % (4 * m_per[i]);
                end else begin
                    m_an[i] <= 4'hF;
                    m_ss[i] <= 8'hFF;
                    m_ft[i] <= 1'b0;
                end
            end
            if (load) begin
                m_sh[0] <= in0;
                m_sh[1] <= in1;
                m_sh[2] <= in2;
                m_sh[3] <= in3;
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        bit         en;
        bit         ld;
        logic [7:0] i0, i1, i2, i3;
        int         reps;
        logic [3:0] x_an;
        logic [7:0] x_ss;
        bit         x_ft;
    } vec_t;

    function automatic vec_t mk(bit e, bit l, logic [7:0] a0, logic [7:0] a1, logic [7:0] a2,
                                logic [7:0] a3, int r, logic [3:0] xa, logic [7:0] xs, bit xf);
        vec_t v;
        v.en = e; v.ld = l; v.i0 = a0; v.i1 = a1; v.i2 = a2; v.i3 = a3;
        v.reps = r; v.x_an = xa; v.x_ss = xs; v.x_ft = xf;
        return v;
    endfunction

    vec_t tbl[$];
    logic [7:0] pats [4];

    initial begin
        // Scan order, load gating, enable freeze, load coinciding with digit-0 entry (N=4 instance).
        tbl.push_back(mk(0,1,8'hC0,8'hF9,8'hA4,8'hB0, 1, 4'hF,8'hFF,0));
        tbl.push_back(mk(1,0,8'hC0,8'hF9,8'hA4,8'hB0, 4, 4'hE,8'hC0,0));
        tbl.push_back(mk(1,0,8'hC0,8'hF9,8'hA4,8'hB0, 4, 4'hD,8'hF9,0));
        tbl.push_back(mk(1,0,8'hC0,8'hF9,8'hA4,8'hB0, 4, 4'hB,8'hA4,0));
        tbl.push_back(mk(1,0,8'hC0,8'hF9,8'hA4,8'hB0, 3, 4'h7,8'hB0,0));
        tbl.push_back(mk(1,0,8'hC0,8'hF9,8'hA4,8'hB0, 1, 4'h7,8'hB0,1));
        tbl.push_back(mk(1,0,8'hC0,8'hF9,8'h99,8'hB0, 4, 4'hE,8'hC0,0));
        tbl.push_back(mk(1,0,8'hC0,8'hF9,8'h99,8'hB0, 4, 4'hD,8'hF9,0));
        tbl.push_back(mk(1,0,8'hC0,8'hF9,8'h99,8'hB0, 4, 4'hB,8'hA4,0));
        tbl.push_back(mk(1,0,8'hC0,8'hF9,8'h99,8'hB0, 3, 4'h7,8'hB0,0));
        tbl.push_back(mk(1,0,8'hC0,8'hF9,8'h99,8'hB0, 1, 4'h7,8'hB0,1));
        tbl.push_back(mk(1,1,8'hC0,8'hF9,8'h99,8'hB0, 1, 4'hE,8'hC0,0));
        tbl.push_back(mk(1,0,8'hC0,8'hF9,8'h99,8'hB0, 3, 4'hE,8'hC0,0));
        tbl.push_back(mk(1,0,8'hC0,8'hF9,8'h99,8'hB0, 4, 4'hD,8'hF9,0));
        tbl.push_back(mk(1,0,8'hC0,8'hF9,8'h99,8'hB0, 4, 4'hB,8'h99,0));
        tbl.push_back(mk(1,0,8'hC0,8'hF9,8'h99,8'hB0, 3, 4'h7,8'hB0,0));
        tbl.push_back(mk(1,0,8'hC0,8'hF9,8'h99,8'hB0, 1, 4'h7,8'hB0,1));
        tbl.push_back(mk(1,0,8'hC0,8'hF9,8'h99,8'hB0, 4, 4'hE,8'hC0,0));
        tbl.push_back(mk(1,0,8'hC0,8'hF9,8'h99,8'hB0, 2, 4'hD,8'hF9,0));
        tbl.push_back(mk(0,0,8'hC0,8'hF9,8'h99,8'hB0,10, 4'hF,8'hFF,0));
        tbl.push_back(mk(1,0,8'hC0,8'hF9,8'h99,8'hB0, 2, 4'hD,8'hF9,0));
        tbl.push_back(mk(1,0,8'hC0,8'hF9,8'h99,8'hB0, 4, 4'hB,8'h99,0));
        tbl.push_back(mk(1,0,8'hC0,8'hF9,8'h99,8'hB0, 3, 4'h7,8'hB0,0));
        tbl.push_back(mk(1,0,8'hC0,8'hF9,8'h99,8'hB0, 1, 4'h7,8'hB0,1));
        tbl.push_back(mk(1,1,8'h80,8'hF9,8'h99,8'hB0, 1, 4'hE,8'hC0,0));
        tbl.push_back(mk(1,0,8'h80,8'hF9,8'h99,8'hB0, 3, 4'hE,8'h80,0));
        tbl.push_back(mk(1,0,8'h80,8'hF9,8'h99,8'hB0, 4, 4'hD,8'hF9,0));

        #1 reset = 1'b1;
        #3;
        chk("reset_an", {4'h0, an4}, 8'h0F);
        chk("reset_sseg", sseg4, 8'hFF);
        chk("reset_ft", {7'h0, ft4}, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[t]) begin
            for (int r = 0; r < tbl[t].reps; r++) begin
                en = tbl[t].en; load = tbl[t].ld;
                in0 = tbl[t].i0; in1 = tbl[t].i1; in2 = tbl[t].i2; in3 = tbl[t].i3;
                @(negedge clk);
                chk($sformatf("tbl%0d_an", t), {4'h0, an4}, {4'h0, tbl[t].x_an});
                chk($sformatf("tbl%0d_sseg", t), sseg4, tbl[t].x_ss);
                chk($sformatf("tbl%0d_ft", t), {7'h0, ft4}, {7'h0, tbl[t].x_ft});
            end
        end
        load = 1'b0;

        // Async reset mid-scan: blanks before any clock edge, shadow contents lost.
        #2 reset = 1'b1;
        #1;
        chk("async_rst_an4", {4'h0, an4}, 8'h0F);
        chk("async_rst_sseg4", sseg4, 8'hFF);
        chk("async_rst_an3", {4'h0, an3}, 8'h0F);
        chk("async_rst_sseg3", sseg3, 8'hFF);
        #1 reset = 1'b0;
        en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("post_rst_an", {4'h0, an4}, {4'h0, 4'hF & ~(4'(1) << ((k / 4) % 4))});
            chk("post_rst_sseg", sseg4, 8'hFF);
        end

        // N=3 wrap: two cycles per digit, 8-cycle frame, three frames.
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        pats[0] = 8'h92; pats[1] = 8'h82; pats[2] = 8'hF8; pats[3] = 8'h90;
        en = 1'b0; load = 1'b1;
        in0 = pats[0]; in1 = pats[1]; in2 = pats[2]; in3 = pats[3];
        @(negedge clk);
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            chk("n3_an", {4'h0, an3}, {4'h0, 4'hF & ~(4'(1) << ((k / 2) % 4))});
            chk("n3_sseg", sseg3, pats[(k / 2) % 4]);
            chk("n3_ft", {7'h0, ft3}, {7'h0, (k % 8) == 7});
        end

        // Randomized run against the reference model, both instances.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                #2 reset = 1'b1;
                #2 reset = 1'b0;
            end
            en   = ($urandom_range(0, 7) != 0);
            load = ($urandom_range(0, 7) == 0);
            in0 = 8'($urandom); in1 = 8'($urandom); in2 = 8'($urandom); in3 = 8'($urandom);
            @(negedge clk);
            chk("rnd_an4", {4'h0, an4}, {4'h0, m_an[0]});
            chk("rnd_sseg4", sseg4, m_ss[0]);
            chk("rnd_ft4", {7'h0, ft4}, {7'h0, m_ft[0]});
            chk("rnd_an3", {4'h0, an3}, {4'h0, m_an[1]});
            chk("rnd_sseg3", sseg3, m_ss[1]);
            chk("rnd_ft3", {7'h0, ft3}, {7'h0, m_ft[1]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
